// File: rtl/l2_rr_request_arbiter_pkg.sv
// Shared types and constants for the L2 round-robin request arbiter.
package l2_rr_request_arbiter_pkg;

  localparam int L2_NUM_PORTS = 2;
  localparam int L2_ID_W      = $clog2(L2_NUM_PORTS);
  localparam int L2_ADDR_W    = 30;
  localparam int L2_BURST_W   = 5;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } l2_arb_state_e;

  // Sized for the widest configuration; narrower ports are zero-extended.
  typedef struct packed {
    logic [L2_ADDR_W-1:0]  addr;
    logic                  rnw;
    logic [3:0]            be;
    logic                  is_amo;
    logic [L2_BURST_W-1:0] amo_type_or_burst_size;
  } l2_port_req_t;

  function automatic int unsigned l2_next_ptr(input int unsigned cur, input int unsigned n);
    return (cur >= n - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/l2_rr_request_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr, modulo N.
module rr_priority_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!any && req[j] && (j == ((int'(ptr) + k) % N))) begin
          gnt[j] = 1'b1;
          idx    = IDX_W'(j);
          any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/l2_rr_request_arbiter.sv
// Round-robin arbiter merging per-core L2 requests into one downstream stream,
// with write-data ownership tracking and read-return routing by ID.
module l2_rr_request_arbiter
  import l2_rr_request_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = L2_NUM_PORTS,
  parameter int ADDR_W    = L2_ADDR_W,
  parameter int BURST_W   = L2_BURST_W,
  parameter int ID_W      = $clog2(NUM_PORTS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              p_request_valid,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  p_addr,
  input  logic [NUM_PORTS-1:0]              p_rnw,
  input  logic [NUM_PORTS-1:0]              p_is_amo,
  input  logic [NUM_PORTS-1:0][3:0]         p_be,
  input  logic [NUM_PORTS-1:0][BURST_W-1:0] p_amo_type_or_burst_size,
  output logic [NUM_PORTS-1:0]              p_request_pop,
  input  logic [NUM_PORTS-1:0][31:0]        p_wr_data,
  input  logic [NUM_PORTS-1:0]              p_wr_data_valid,
  output logic [NUM_PORTS-1:0]              p_wr_data_read,
  output logic [31:0]                       p_rd_data,
  output logic [NUM_PORTS-1:0]              p_rd_data_valid,
  output logic                              request_valid,
  output logic [ADDR_W-1:0]                 addr,
  output logic                              rnw,
  output logic [3:0]                        be,
  output logic                              is_amo,
  output logic [BURST_W-1:0]                amo_type_or_burst_size,
  output logic [ID_W-1:0]                   id,
  input  logic                              request_pop,
  output logic [31:0]                       wr_data,
  output logic                              wr_data_valid,
  input  logic                              wr_data_read,
  input  logic [31:0]                       rd_data,
  input  logic [ID_W-1:0]                   rd_id,
  input  logic                              rd_data_valid
);

  l2_arb_state_e        state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      owner_q, owner_d;
  logic [ID_W-1:0]      wr_owner_q, wr_owner_d;
  logic                 wr_busy_q, wr_busy_d;
  logic [5:0]           beats_left_q, beats_left_d;
  l2_port_req_t         req_q, pick_req;
  logic [NUM_PORTS-1:0] elig, pick_gnt;
  logic [ID_W-1:0]      pick_idx;
  logic                 pick_any;
  logic                 capture;
  logic                 pop_hold;

  // Writes and AMOs need the single write-data channel, so they wait for it.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      elig[i] = p_request_valid[i] & ((p_rnw[i] & ~p_is_amo[i]) | ~wr_busy_q);
    end
  end

  rr_priority_picker #(
    .N     (NUM_PORTS),
    .IDX_W (ID_W)
  ) u_picker (
    .req (elig),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    pick_req = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick_gnt[i]) begin
        pick_req.addr                   = L2_ADDR_W'(p_addr[i]);
        pick_req.rnw                    = p_rnw[i];
        pick_req.be                     = p_be[i];
        pick_req.is_amo                 = p_is_amo[i];
        pick_req.amo_type_or_burst_size = L2_BURST_W'(p_amo_type_or_burst_size[i]);
      end
    end
  end

  assign capture  = (state_q == ARB) && pick_any;
  assign pop_hold = (state_q == HOLD) && request_pop;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      wr_owner_q   <= '0;
      wr_busy_q    <= 1'b0;
      beats_left_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      wr_owner_q   <= wr_owner_d;
      wr_busy_q    <= wr_busy_d;
      beats_left_q <= beats_left_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) req_q <= pick_req;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB:  if (pick_any) state_d = HOLD;
      HOLD: if (request_pop) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (capture)  owner_d  = pick_idx;
    if (pop_hold) rr_ptr_d = ID_W'(l2_next_ptr(int'(owner_q), NUM_PORTS));
  end

  // Capture only happens with wr_busy_q clear for writes, so it never races a decrement.
  always_comb begin
    wr_owner_d   = wr_owner_q;
    wr_busy_d    = wr_busy_q;
    beats_left_d = beats_left_q;
    if (capture && (!pick_req.rnw || pick_req.is_amo)) begin
      wr_owner_d   = pick_idx;
      wr_busy_d    = 1'b1;
      beats_left_d = pick_req.is_amo ? 6'd1 : (6'(pick_req.amo_type_or_burst_size) + 6'd1);
    end else if (wr_busy_q && wr_data_read) begin
      beats_left_d = beats_left_q - 6'd1;
      if (beats_left_q == 6'd1) wr_busy_d = 1'b0;
    end
  end

  // Output logic
  always_comb begin
    request_valid          = (state_q == HOLD);
    addr                   = ADDR_W'(req_q.addr);
    rnw                    = req_q.rnw;
    be                     = req_q.be;
    is_amo                 = req_q.is_amo;
    amo_type_or_burst_size = BURST_W'(req_q.amo_type_or_burst_size);
    id                     = owner_q;
    p_request_pop          = '0;
    wr_data                = '0;
    wr_data_valid          = 1'b0;
    p_wr_data_read         = '0;
    p_rd_data              = rd_data;
    p_rd_data_valid        = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pop_hold && (owner_q == ID_W'(i))) p_request_pop[i] = 1'b1;
      if (wr_busy_q && (wr_owner_q == ID_W'(i))) begin
        wr_data           = p_wr_data[i];
        wr_data_valid     = p_wr_data_valid[i];
        p_wr_data_read[i] = wr_data_read;
      end
      if (rd_data_valid && (int'(rd_id) == i)) p_rd_data_valid[i] = 1'b1;
    end
  end

endmodule

// File: tb/tb_l2_rr_request_arbiter.sv
// Directed bench: read-return vector table plus hand-written arbitration and write-ownership sequences.
module tb_l2_rr_request_arbiter;

  localparam int NP = 2;
  localparam int AW = 30;
  localparam int BW = 5;
  localparam int IW = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NP-1:0]          p_request_valid, p_rnw, p_is_amo, p_request_pop;
  logic [NP-1:0][AW-1:0]  p_addr;
  logic [NP-1:0][3:0]     p_be;
  logic [NP-1:0][BW-1:0]  p_burst;
  logic [NP-1:0][31:0]    p_wr_data;
  logic [NP-1:0]          p_wr_data_valid, p_wr_data_read, p_rd_data_valid;
  logic [31:0]            p_rd_data;
  logic                   request_valid, rnw, is_amo, request_pop;
  logic [AW-1:0]          addr;
  logic [3:0]             be;
  logic [BW-1:0]          amo_field;
  logic [IW-1:0]          id, rd_id;
  logic [31:0]            wr_data, rd_data;
  logic                   wr_data_valid, wr_data_read, rd_data_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [IW-1:0] rid;
    logic          vld;
    logic [31:0]   data;
    logic [NP-1:0] exp_vld;
  } rd_vec_t;

  rd_vec_t tbl[6];

  l2_rr_request_arbiter #(
    .NUM_PORTS (NP),
    .ADDR_W    (AW),
    .BURST_W   (BW),
    .ID_W      (IW)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .p_request_valid          (p_request_valid),
    .p_addr                   (p_addr),
    .p_rnw                    (p_rnw),
    .p_is_amo                 (p_is_amo),
    .p_be                     (p_be),
    .p_amo_type_or_burst_size (p_burst),
    .p_request_pop            (p_request_pop),
    .p_wr_data                (p_wr_data),
    .p_wr_data_valid          (p_wr_data_valid),
    .p_wr_data_read           (p_wr_data_read),
    .p_rd_data                (p_rd_data),
    .p_rd_data_valid          (p_rd_data_valid),
    .request_valid            (request_valid),
    .addr                     (addr),
    .rnw                      (rnw),
    .be                       (be),
    .is_amo                   (is_amo),
    .amo_type_or_burst_size   (amo_field),
    .id                       (id),
    .request_pop              (request_pop),
    .wr_data                  (wr_data),
    .wr_data_valid            (wr_data_valid),
    .wr_data_read             (wr_data_read),
    .rd_data                  (rd_data),
    .rd_id                    (rd_id),
    .rd_data_valid            (rd_data_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    p_request_valid = '0; p_rnw = '0; p_is_amo = '0; p_addr = '0; p_be = '0;
    p_burst = '0; p_wr_data = '0; p_wr_data_valid = '0; request_pop = 1'b0;
    wr_data_read = 1'b0; rd_data = '0; rd_id = '0; rd_data_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int p, input logic r, input logic amo,
                         input logic [AW-1:0] a, input logic [BW-1:0] b);
    p_request_valid[p] = 1'b1;
    p_rnw[p]           = r;
    p_is_amo[p]        = amo;
    p_addr[p]          = a;
    p_be[p]            = 4'hF;
    p_burst[p]         = b;
  endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    while (!request_valid && n < 8) begin
      tick();
      n++;
    end
    chk({nm, "_grant_seen"}, request_valid, 1);
  endtask

  task automatic pop_cur(input string nm, input logic [NP-1:0] exp_pop);
    request_pop = 1'b1;
    #1;
    chk({nm, "_pop"}, p_request_pop, exp_pop);
    tick();
    request_pop = 1'b0;
  endtask

  initial begin
    tbl[0] = '{rid: 2'd0, vld: 1'b1, data: 32'h1111_0000, exp_vld: 2'b01};
    tbl[1] = '{rid: 2'd1, vld: 1'b1, data: 32'h2222_0001, exp_vld: 2'b10};
    tbl[2] = '{rid: 2'd2, vld: 1'b1, data: 32'h3333_0002, exp_vld: 2'b00};
    tbl[3] = '{rid: 2'd3, vld: 1'b1, data: 32'h4444_0003, exp_vld: 2'b00};
    tbl[4] = '{rid: 2'd1, vld: 1'b0, data: 32'h5555_0004, exp_vld: 2'b00};
    tbl[5] = '{rid: 2'd0, vld: 1'b0, data: 32'h6666_0005, exp_vld: 2'b00};

    do_reset();
    #1;
    chk("rst_request_valid", request_valid, 0);
    chk("rst_p_request_pop", p_request_pop, 0);
    chk("rst_p_wr_data_read", p_wr_data_read, 0);
    chk("rst_wr_data_valid", wr_data_valid, 0);
    chk("rst_p_rd_data_valid", p_rd_data_valid, 0);

    // Single read from port 0: one-cycle grant latency, then four return beats.
    set_req(0, 1'b1, 1'b0, 30'h100, 5'd3);
    tick();
    chk("t1_request_valid", request_valid, 1);
    chk("t1_id", id, 0);
    chk("t1_addr", addr, 30'h100);
    chk("t1_rnw", rnw, 1);
    chk("t1_burst", amo_field, 3);
    chk("t1_no_pop_yet", p_request_pop, 0);
    pop_cur("t1", 2'b01);
    p_request_valid = '0;
    #1;
    chk("t1_after_pop_idle", request_valid, 0);
    for (int b = 0; b < 4; b++) begin
      rd_id = 2'd0; rd_data_valid = 1'b1; rd_data = 32'hA0 + 32'(b);
      #1;
      chk("t1_rd_valid", p_rd_data_valid, 2'b01);
      chk("t1_rd_data", p_rd_data, 32'hA0 + 32'(b));
      tick();
    end
    rd_data_valid = 1'b0;

    // Both ports reading continuously: strict alternation from pointer 0.
    do_reset();
    set_req(0, 1'b1, 1'b0, 30'h200, 5'd0);
    set_req(1, 1'b1, 1'b0, 30'h300, 5'd0);
    for (int k = 0; k < 5; k++) begin
      wait_req("t2");
      chk("t2_id", id, k % 2);
      chk("t2_addr", addr, (k % 2) ? 30'h300 : 30'h200);
      pop_cur("t2", (k % 2) ? 2'b10 : 2'b01);
    end
    p_request_valid = '0;

    // Port 1 burst write of 8 beats; port 0 read slips in, port 0 write waits.
    set_req(1, 1'b0, 1'b0, 30'h400, 5'd7);
    wait_req("t3w");
    chk("t3_id", id, 1);
    chk("t3_rnw", rnw, 0);
    chk("t3_burst", amo_field, 7);
    pop_cur("t3w", 2'b10);
    p_request_valid = '0;
    set_req(0, 1'b1, 1'b0, 30'h500, 5'd0);
    p_wr_data[1] = 32'd0; p_wr_data_valid[1] = 1'b1; wr_data_read = 1'b1;
    p_wr_data[0] = 32'hDEAD; p_wr_data_valid[0] = 1'b1;
    #1;
    chk("t3_wr_data0", wr_data, 0);
    chk("t3_wr_valid", wr_data_valid, 1);
    chk("t3_wr_read_route", p_wr_data_read, 2'b10);
    chk("t3_no_req_yet", request_valid, 0);
    tick();
    p_wr_data[1] = 32'd1;
    #1;
    chk("t3_read_granted", request_valid, 1);
    chk("t3_read_id", id, 0);
    chk("t3_read_rnw", rnw, 1);
    chk("t3_wr_data1", wr_data, 1);
    pop_cur("t3r", 2'b01);
    set_req(0, 1'b0, 1'b0, 30'h600, 5'd0);
    for (int b = 2; b < 8; b++) begin
      p_wr_data[1] = 32'(b);
      #1;
      chk("t3_wr_data", wr_data, 32'(b));
      chk("t3_write_held", request_valid, 0);
      tick();
    end
    wr_data_read = 1'b0;
    p_wr_data_valid[1] = 1'b0;
    #1;
    chk("t3_same_cycle_not_eligible", request_valid, 0);
    chk("t3_busy_cleared", wr_data_valid, 0);
    tick();
    chk("t3_p0_write_granted", request_valid, 1);
    chk("t3_p0_write_id", id, 0);
    chk("t3_p0_write_rnw", rnw, 0);
    pop_cur("t3p0", 2'b01);
    p_request_valid = '0;
    p_wr_data[0] = 32'h55; wr_data_read = 1'b1;
    #1;
    chk("t3_p0_wr_read", p_wr_data_read, 2'b01);
    chk("t3_p0_wr_data", wr_data, 32'h55);
    tick();
    wr_data_read = 1'b0;
    #1;
    chk("t3_p0_single_beat_done", wr_data_valid, 0);

    // AMO: exactly one data beat regardless of the opcode field.
    set_req(0, 1'b0, 1'b1, 30'h700, 5'h0A);
    wait_req("t4");
    chk("t4_is_amo", is_amo, 1);
    chk("t4_opcode", amo_field, 5'h0A);
    pop_cur("t4", 2'b01);
    p_request_valid = '0; p_is_amo = '0;
    p_wr_data[0] = 32'h77; p_wr_data_valid[0] = 1'b1;
    #1;
    chk("t4_wr_valid", wr_data_valid, 1);
    chk("t4_wr_data", wr_data, 32'h77);
    wr_data_read = 1'b1;
    #1;
    chk("t4_wr_read", p_wr_data_read, 2'b01);
    tick();
    wr_data_read = 1'b0;
    #1;
    chk("t4_amo_busy_clear", wr_data_valid, 0);
    p_wr_data_valid = '0;

    // Reset while holding a port 1 read and a port 0 write is mid-burst.
    set_req(0, 1'b0, 1'b0, 30'h800, 5'd3);
    wait_req("t5w");
    chk("t5_write_id", id, 0);
    pop_cur("t5w", 2'b01);
    p_request_valid = '0;
    p_wr_data_valid[0] = 1'b1;
    set_req(1, 1'b1, 1'b0, 30'h900, 5'd0);
    wait_req("t5r");
    chk("t5_read_id", id, 1);
    rst = 1'b1;
    tick();
    request_pop = 1'b1; wr_data_read = 1'b1;
    #1;
    chk("t5_rst_request_valid", request_valid, 0);
    chk("t5_rst_no_pop", p_request_pop, 0);
    chk("t5_rst_wr_valid", wr_data_valid, 0);
    chk("t5_rst_wr_read", p_wr_data_read, 0);
    chk("t5_rst_rd_valid", p_rd_data_valid, 0);
    rst = 1'b0;
    clear_inputs();
    set_req(0, 1'b1, 1'b0, 30'hA00, 5'd0);
    set_req(1, 1'b1, 1'b0, 30'hB00, 5'd0);
    tick();
    chk("t5_post_rst_grant", request_valid, 1);
    chk("t5_rr_ptr_zero", id, 0);
    p_request_valid = '0;

    // Read-return routing vectors, including out-of-range IDs.
    for (int i = 0; i < 6; i++) begin
      rd_id = tbl[i].rid; rd_data_valid = tbl[i].vld; rd_data = tbl[i].data;
      #1;
      chk($sformatf("rd_vec%0d_valid", i), p_rd_data_valid, tbl[i].exp_vld);
      chk($sformatf("rd_vec%0d_data", i), p_rd_data, tbl[i].data);
    end
    rd_data_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_rr_request_arbiter.md
# l2_rr_request_arbiter

Round-robin arbiter that shares one L2-style request stream, consumed by the single AXI bridge, between NUM_PORTS core-side requesters (one per core/cache). It latches one winning request and holds it stable until the bridge pops it. It keeps write-data ownership until every write beat has been consumed. It routes read-return beats back to the issuing port by ID.

## Interface
- NUM_PORTS, 2, number of requesters (2..4)
- ADDR_W, 30, word address width
- BURST_W, 5, amo_type_or_burst_size width (burst length minus 1, or AMO opcode)
- ID_W, $clog2(NUM_PORTS), downstream request/return ID width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- p_request_valid  in  NUM_PORTS  per-port request valid; held until p_request_pop
- p_addr  in  NUM_PORTS×ADDR_W  per-port word address
- p_rnw, p_is_amo  in  NUM_PORTS each  read-not-write; atomic flag
- p_be  in  NUM_PORTS×4  byte enables
- p_amo_type_or_burst_size  in  NUM_PORTS×BURST_W  burst length−1 or AMO opcode
- p_request_pop  out  NUM_PORTS  one-hot pulse: port's request accepted downstream
- p_wr_data  in  NUM_PORTS×32; p_wr_data_valid  in  NUM_PORTS  per-port write-data FIFO head
- p_wr_data_read  out  NUM_PORTS  write beat consumed
- p_rd_data  out  32; p_rd_data_valid  out  NUM_PORTS  broadcast data, one-hot valid
- request_valid, addr, rnw, be, is_amo, amo_type_or_burst_size, id  out  1/ADDR_W/1/4/1/BURST_W/ID_W  downstream request
- request_pop  in  1  downstream accepted current request
- wr_data  out  32; wr_data_valid  out  1; wr_data_read  in  1  downstream write-data stream
- rd_data  in  32; rd_id  in  ID_W; rd_data_valid  in  1  downstream read return

## Operation
- FSM for the request path: ARB → HOLD → ARB.
  - ARB: pick the first valid port at or after rr_ptr, modulo NUM_PORTS. A write or AMO candidate is skipped while wr_busy=1. If a winner exists, register its fields and id=index, then go to HOLD.
  - HOLD: request_valid=1 with fields frozen. On request_pop, pulse p_request_pop[owner], set rr_ptr=owner+1 (wrapping NUM_PORTS−1→0), and return to ARB.
- Write ownership is independent of the FSM. It is set when a non-rnw or is_amo request enters HOLD:
  - wr_owner=index, wr_busy=1.
  - beats_left = is_amo ? 1 : amo_type_or_burst_size+1, in a 6-bit counter.
- Write-data muxing: wr_data and wr_data_valid come from p_*[wr_owner] while wr_busy=1, else 0. p_wr_data_read[wr_owner] = wr_data_read & wr_busy.
- Each wr_data_read decrements beats_left. The transition 1→0 clears wr_busy. wr_busy may outlive the pop, so reads from any port may be granted meanwhile.
- Read return: p_rd_data=rd_data and p_rd_data_valid[rd_id]=rd_data_valid, purely combinational. An rd_id ≥ NUM_PORTS is dropped.
- Reset: state=ARB, rr_ptr=0, wr_busy=0, beats_left=0. All outputs are 0 (request_valid, p_request_pop, p_wr_data_read, wr_data_valid, p_rd_data_valid).
- rst mid-HOLD or mid-write aborts without pops. Requesters are reset by the same rst.

## Timing
- Grant latency: request_valid rises 1 cycle after p_request_valid is sampled in ARB.
- Pop-to-next: the cycle after request_pop, the FSM is in ARB. The next request_valid comes 1 cycle later, so minimum spacing is 2 cycles per request.
- p_request_pop is the same cycle as request_pop (combinational from the owner register).
- wr_data, wr_data_read, and the read-return paths are combinational, with zero added latency.
- Simultaneous wr_busy clear and an ARB candidate write: the write is not eligible until the cycle after wr_busy=0.
- A request_pop asserted while in ARB is ignored.

## Structure
- The shared package holds:
  - l2_port_req_t, a struct of addr, rnw, be, is_amo, amo_type_or_burst_size.
  - L2_NUM_PORTS and L2_ID_W.
- One sub-module, rr_priority_picker: inputs are a request vector and a pointer; outputs are a one-hot grant and an index. It is combinational.

## Test plan
- Single read, port 0, addr 0x100, burst 3 → request_valid 1 cycle later with id=0. Pop pulses p_request_pop[0]. Four rd_data beats with rd_id=0 appear only on p_rd_data_valid[0].
- Both ports request reads continuously with 5 pops → grant order 0,1,0,1,0. rr_ptr wraps.
- Port 1 write with burst 7, data 0..7: after pop, port 0 write is held off until the 8th wr_data_read. A port 0 read is granted during the data phase.
- AMO from port 0 → beats_left=1, and wr_busy clears after a single wr_data_read.
- rst asserted mid-HOLD, with a write in flight → next cycle all outputs are 0 and rr_ptr=0. No p_request_pop is emitted.
- rd_data_valid with rd_id=3 and NUM_PORTS=2 → no p_rd_data_valid bit asserted.
